pc_npc_sequencer: RTL

//  Holds the fetch PC/nPC pair that consumes branch_taken/branch_target_pc from the branch condition handler.

---
 rtl/pc_npc_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pc_npc_sequencer.sv
// Fetch PC/nPC pair with MIPS single-delay-slot redirect and stall-time redirect capture.
// Optional applied-redirect counter enabled by defining TAKEN_COUNT_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | sequential fetch, accepts redirects
// PEND  | redirect captured during a stall, waiting for pc_le
// SLOT  | pc holds the delay-slot instruction of a taken branch
module pc_npc_sequencer #(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_le,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target_pc,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] npc,
   output logic              delay_slot,
   output logic              redirect_pending,
   output logic [15:0]       branch_count
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_PEND = 2'b01,
      ST_SLOT = 2'b10
   } state_t;

   localparam logic [ADDR_W-1:0] INC  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] PC0  = {RESET_PC[ADDR_W-1:2], 2'b00};
   localparam logic [ADDR_W-1:0] NPC0 = PC0 + INC;

   state_t            state_q, state_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt;
   logic [ADDR_W-1:0] npc_q, npc_nxt;
   logic [ADDR_W-1:0] tgt_q, tgt_nxt;
   logic              ds_q, ds_nxt;
   logic              rp_q, rp_nxt;
   logic [ADDR_W-1:0] tgt_in;

   assign tgt_in = {branch_target_pc[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         pc_q    <= PC0;
         npc_q   <= NPC0;
         tgt_q   <= '0;
         ds_q    <= 1'b0;
         rp_q    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         pc_q    <= pc_nxt;
         npc_q   <= npc_nxt;
         tgt_q   <= tgt_nxt;
         ds_q    <= ds_nxt;
         rp_q    <= rp_nxt;
      end
   end

   always_comb begin
      state_nxt = ST_RUN;
      case (state_q)
         ST_RUN: begin
            if (branch_taken)
               state_nxt = pc_le ? ST_SLOT : ST_PEND;
            else
               state_nxt = ST_RUN;
         end
         ST_PEND: state_nxt = pc_le ? ST_SLOT : ST_PEND;
         ST_SLOT: state_nxt = pc_le ? ST_RUN : ST_SLOT;
         default: state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      pc_nxt  = pc_q;
      npc_nxt = npc_q;
      tgt_nxt = tgt_q;
      ds_nxt  = ds_q;
      rp_nxt  = rp_q;
      case (state_q)
         ST_RUN: begin
            if (pc_le) begin
               pc_nxt = npc_q;
               if (branch_taken) begin
                  npc_nxt = tgt_in;
                  ds_nxt  = 1'b1;
               end else begin
                  npc_nxt = npc_q + INC;
               end
            end else if (branch_taken) begin
               tgt_nxt = tgt_in;
               rp_nxt  = 1'b1;
            end
         end
         ST_PEND: begin
            // later redirects are dropped: the first captured target wins
            if (pc_le) begin
               pc_nxt  = npc_q;
               npc_nxt = tgt_q;
               rp_nxt  = 1'b0;
               ds_nxt  = 1'b1;
            end
         end
         ST_SLOT: begin
            if (pc_le) begin
               pc_nxt  = npc_q;
               npc_nxt = npc_q + INC;
               ds_nxt  = 1'b0;
            end
         end
         default: begin
            ds_nxt = 1'b0;
            rp_nxt = 1'b0;
         end
      endcase
   end

   assign pc               = pc_q;
   assign npc              = npc_q;
   assign delay_slot       = ds_q;
   assign redirect_pending = rp_q;

`ifdef TAKEN_COUNT_EN
   logic        slot_entry;
   logic [15:0] cnt_q;

   assign slot_entry = pc_le && ((state_q == ST_RUN && branch_taken) || state_q == ST_PEND);

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else if (slot_entry && cnt_q != 16'hFFFF)
         cnt_q <= cnt_q + 16'd1;
   end

   assign branch_count = cnt_q;
`else
   assign branch_count = 16'h0000;
`endif

endmodule
